// File: rtl/delay_pkg.sv
// delay_pkg: shared constants and state type for the delay-line tap controller
package delay_pkg;
  localparam int TAPS    = 512;
  localparam int IDX_W   = 9;
  localparam int FILT_TH = 8;
  localparam int SETTLE  = 8;
  localparam int FILT_W  = $clog2(FILT_TH) + 2;
  localparam int SET_W   = $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0] INIT_TAP  = IDX_W'(TAPS / 2);
  localparam logic [IDX_W-1:0] INIT_STEP = IDX_W'(TAPS / 4);
  typedef enum logic [1:0] {IDLE, SEARCH, TRACK} state_e;
endpackage

// File: rtl/delay_tap_decode.sv
// delay_tap_decode: registered tap index to one-hot enable, resetting to bit 0
module delay_tap_decode #(
  parameter int TAPS  = 512,
  parameter int IDX_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] tap,
  output logic [TAPS-1:0]  en
);
  logic [TAPS-1:0] en_q;
  always_ff @(posedge clk) begin
    if (rst) en_q <= TAPS'(1);
    else en_q <= TAPS'(1) << tap;
  end
  assign en = en_q;
endmodule

// File: rtl/delay_tap_ctrl.sv
// delay_tap_ctrl: binary-search then filtered +/-1 tracking lock of a delay-line tap
module delay_tap_ctrl
  import delay_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pd_valid,
  input  logic             pd_late,
  input  logic             manual_en,
  input  logic [IDX_W-1:0] manual_tap,
  output logic [TAPS-1:0]  en,
  output logic [IDX_W-1:0] tap,
  output logic             busy,
  output logic             locked,
  output logic             sat_err
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] tap_q, tap_d, step_q, step_d;
  logic signed [FILT_W-1:0] filt_q, filt_d, filt_n;
  logic [SET_W-1:0] settle_q, settle_d;
  logic sat_q, sat_d, go, acc, up_hit, dn_hit;
  assign go     = start && !manual_en;
  assign acc    = pd_valid && settle_q == '0 && state_q != IDLE && !manual_en && !start;
  assign filt_n = pd_late ? filt_q - FILT_W'(1) : filt_q + FILT_W'(1);
  assign up_hit = filt_n == FILT_W'(FILT_TH);
  assign dn_hit = filt_n == FILT_W'(-FILT_TH);
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    step_d  = step_q;
    filt_d  = filt_q;
    sat_d   = sat_q;
    if (manual_en) begin
      state_d = IDLE;
      tap_d   = manual_tap;
      filt_d  = '0;
    end else if (start) begin
      state_d = SEARCH;
      tap_d   = INIT_TAP;
      step_d  = INIT_STEP;
      filt_d  = '0;
      sat_d   = 1'b0;
    end else if (acc && state_q == SEARCH) begin
      tap_d   = pd_late ? tap_q - step_q : tap_q + step_q;
      step_d  = step_q >> 1;
      state_d = step_q == IDX_W'(1) ? TRACK : SEARCH;
      filt_d  = '0;
    end else if (acc) begin
      filt_d = (up_hit || dn_hit) ? '0 : filt_n;
      // a bound hit flags sat_err and leaves the tap (and so settle) untouched
      if (up_hit) begin
        if (tap_q == IDX_W'(TAPS - 1)) sat_d = 1'b1;
        else tap_d = tap_q + IDX_W'(1);
      end
      if (dn_hit) begin
        if (tap_q == '0) sat_d = 1'b1;
        else tap_d = tap_q - IDX_W'(1);
      end
    end
    settle_d = (go || tap_d != tap_q) ? SET_W'(SETTLE)
             : settle_q == '0 ? '0 : settle_q - SET_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      step_q   <= INIT_STEP;
      filt_q   <= '0;
      settle_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      step_q   <= step_d;
      filt_q   <= filt_d;
      settle_q <= settle_d;
      sat_q    <= sat_d;
    end
  end
  delay_tap_decode #(.TAPS(TAPS), .IDX_W(IDX_W)) u_dec (
    .clk(clk),
    .rst(rst),
    .tap(tap_q),
    .en (en)
  );
  assign tap     = tap_q;
  assign busy    = state_q != IDLE;
  assign locked  = state_q == TRACK;
  assign sat_err = sat_q;
endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb_delay_tap_ctrl: directed and randomized checks of delay_tap_ctrl against a behavioural model
module tb_delay_tap_ctrl;
  logic clk = 0, rst = 0, start = 0, pd_valid = 0, pd_late = 0, manual_en = 0;
  logic [8:0] manual_tap = '0;
  logic [511:0] en;
  logic [8:0] tap;
  logic busy, locked, sat_err;
  int checks = 0, failures = 0;
  int m_tap = 0, m_mode = 0, m_k = 0, m_f = 0, m_set = 0, m_sat = 0, m_en = 0;

  delay_tap_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pd_valid(pd_valid), .pd_late(pd_late),
    .manual_en(manual_en), .manual_tap(manual_tap), .en(en), .tap(tap),
    .busy(busy), .locked(locked), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // mode: 0 idle, 1 search (m_k samples taken), 2 track
  task automatic tick();
    int n_tap = m_tap, n_mode = m_mode, n_k = m_k, n_f = m_f, n_sat = m_sat, n_set;
    int step, dir;
    dir = pd_late ? -1 : 1;
    if (rst) begin
      n_mode = 0; n_tap = 0; n_f = 0; n_sat = 0;
    end else if (manual_en) begin
      n_mode = 0; n_tap = int'(manual_tap); n_f = 0;
    end else if (start) begin
      n_mode = 1; n_tap = 256; n_k = 0; n_f = 0; n_sat = 0;
    end else if (pd_valid && m_set == 0 && m_mode != 0) begin
      if (m_mode == 1) begin
        step = 128 >> m_k;
        n_tap = m_tap + dir * step;
        n_k = m_k + 1;
        if (n_k == 8) begin n_mode = 2; n_f = 0; end
      end else begin
        n_f = m_f + dir;
        if (n_f == 8 || n_f == -8) begin
          if (m_tap + dir < 0 || m_tap + dir > 511) n_sat = 1;
          else n_tap = m_tap + dir;
          n_f = 0;
        end
      end
    end
    if (rst) n_set = 0;
    else if (n_tap != m_tap || (start && !manual_en)) n_set = 8;
    else n_set = m_set > 0 ? m_set - 1 : 0;
    @(posedge clk);
    #1;
    m_en = rst ? 0 : m_tap;
    m_tap = n_tap; m_mode = n_mode; m_k = n_k; m_f = n_f; m_set = n_set; m_sat = n_sat;
  endtask

  task automatic pd(input bit late);
    pd_valid = 0;
    for (int i = 0; i < 20 && m_set != 0; i++) tick();
    pd_valid = 1; pd_late = late;
    tick();
    pd_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic search_to(input int target);
    int cur = 256;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      pd(cur > target);
      cur = cur > target ? cur - (128 >> i) : cur + (128 >> i);
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0;
    checks += 6;
    if (tap !== 9'd0) begin failures++; $display("FAIL reset_tap got=%0d exp=0", tap); end
    if (en !== 512'd1) begin failures++; $display("FAIL reset_en got=%h exp=1", en); end
    if ($countones(en) != 1) begin failures++; $display("FAIL reset_popcount got=%0d exp=1", $countones(en)); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    if (sat_err !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat_err); end
  endtask

  task automatic test_search_low();
    pulse_start();
    checks += 2;
    if (tap !== 9'd256) begin failures++; $display("FAIL low_start_tap got=%0d exp=256", tap); end
    if (busy !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL low_start_flags got=%b%b exp=10", busy, locked); end
    for (int i = 0; i < 8; i++) begin
      pd(1);
      checks++;
      if (tap !== 9'(128 >> i)) begin failures++; $display("FAIL low_tap[%0d] got=%0d exp=%0d", i, tap, 128 >> i); end
      checks++;
      if (locked !== (i == 7)) begin failures++; $display("FAIL low_locked[%0d] got=%b exp=%b", i, locked, i == 7); end
    end
    tick();
    checks++;
    if (en !== 512'd2) begin failures++; $display("FAIL low_en got=%h exp=%h", en, 512'd2); end
  endtask

  task automatic test_search_high_settle();
    int exp_tap = 256;
    pulse_start();
    pd_valid = 1; pd_late = 1;
    for (int i = 0; i < 3; i++) tick();
    pd_valid = 0;
    checks++;
    if (tap !== 9'd256) begin failures++; $display("FAIL settle_ignore got=%0d exp=256", tap); end
    for (int i = 0; i < 8; i++) begin
      pd(0);
      exp_tap += 128 >> i;
      pd_valid = 1; pd_late = 1; tick(); pd_valid = 0;
      checks++;
      if (tap !== 9'(exp_tap)) begin failures++; $display("FAIL high_tap[%0d] got=%0d exp=%0d", i, tap, exp_tap); end
    end
    checks++;
    if (tap !== 9'd511 || locked !== 1'b1) begin failures++; $display("FAIL high_final got=%0d/%b exp=511/1", tap, locked); end
  endtask

  task automatic test_track_step();
    search_to(301);
    for (int i = 0; i < 8; i++) pd(1);
    checks++;
    if (tap !== 9'd300 || locked !== 1'b1) begin failures++; $display("FAIL track_300 got=%0d/%b exp=300/1", tap, locked); end
    for (int i = 0; i < 8; i++) pd(0);
    checks += 2;
    if (tap !== 9'd301) begin failures++; $display("FAIL track_up got=%0d exp=301", tap); end
    if (en[300] !== 1'b1 || en[301] !== 1'b0) begin failures++; $display("FAIL track_en_lag got=%b%b exp=01", en[301], en[300]); end
    tick();
    checks++;
    if (en[301] !== 1'b1 || en[300] !== 1'b0) begin failures++; $display("FAIL track_en got=%b%b exp=10", en[301], en[300]); end
    for (int i = 0; i < 32; i++) pd(i % 2 == 1);
    checks++;
    if (tap !== 9'd301 || locked !== 1'b1) begin failures++; $display("FAIL track_alt got=%0d/%b exp=301/1", tap, locked); end
  endtask

  task automatic test_saturation();
    search_to(511);
    for (int i = 0; i < 8; i++) pd(0);
    checks += 2;
    if (tap !== 9'd511) begin failures++; $display("FAIL sat_tap got=%0d exp=511", tap); end
    if (sat_err !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", sat_err); end
    pulse_start();
    checks++;
    if (sat_err !== 1'b0 || tap !== 9'd256) begin failures++; $display("FAIL sat_clear got=%b/%0d exp=0/256", sat_err, tap); end
  endtask

  task automatic test_manual();
    pulse_start();
    pd(0);
    manual_en = 1; manual_tap = 9'd37; start = 1;
    tick();
    start = 0;
    checks += 2;
    if (tap !== 9'd37) begin failures++; $display("FAIL manual_tap got=%0d exp=37", tap); end
    if (busy !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL manual_flags got=%b%b exp=00", busy, locked); end
    tick();
    checks++;
    if (en !== (512'd1 << 37)) begin failures++; $display("FAIL manual_en_vec got_bit37=%b pop=%0d exp=1/1", en[37], $countones(en)); end
    manual_en = 0; manual_tap = 9'd99;
    tick(); tick();
    checks++;
    if (tap !== 9'd37 || busy !== 1'b0) begin failures++; $display("FAIL manual_hold got=%0d/%b exp=37/0", tap, busy); end
  endtask

  task automatic test_rst_mid();
    pulse_start();
    pd(1);
    rst = 1; tick(); rst = 0;
    checks++;
    if (tap !== 9'd0 || en !== 512'd1 || busy !== 1'b0 || locked !== 1'b0) begin
      failures++; $display("FAIL rst_mid got tap=%0d en0=%b busy=%b exp=0/1/0", tap, en[0], busy);
    end
  endtask

  task automatic test_random();
    int man_left = 0;
    logic [511:0] exp_en;
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 599) == 0;
      if (man_left == 0 && $urandom_range(0, 149) == 0) man_left = $urandom_range(1, 6);
      manual_en = man_left != 0;
      if (man_left != 0) man_left--;
      manual_tap = 9'($urandom);
      start = $urandom_range(0, 199) == 0;
      pd_valid = $urandom_range(0, 2) != 0;
      pd_late = $urandom_range(0, 1) == 1;
      tick();
      exp_en = 512'd1 << m_en;
      checks++;
      if (tap !== 9'(m_tap) || en !== exp_en || busy !== (m_mode != 0) ||
          locked !== (m_mode == 2) || sat_err !== m_sat[0]) begin
        failures++;
        $display("FAIL random[%0d] got tap=%0d busy=%b locked=%b sat=%b pop=%0d exp tap=%0d mode=%0d sat=%0d en_idx=%0d",
                 c, tap, busy, locked, sat_err, $countones(en), m_tap, m_mode, m_sat, m_en);
      end
    end
    rst = 0; manual_en = 0; start = 0; pd_valid = 0;
  endtask

  initial begin
    test_reset();
    test_search_low();
    test_search_high_settle();
    test_track_step();
    test_saturation();
    test_manual();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_tap_ctrl.md
Name: delay_tap_ctrl

Overview:
- Sequential controller directly upstream of the 512-tap delay line.
- Produces the one-hot tap-enable vector that selects which delay cell drives the line output.
- Locks the tap using early/late samples from an external phase detector: a binary search for coarse lock, then filtered ±1 tracking.
- Also supports a manual tap override for characterisation.

Parameters:
- TAPS, 512: number of delay cells; width of en.
- IDX_W, 9: tap index width, clog2(TAPS).
- FILT_TH, 8: net early/late count that triggers one tap step in TRACK.
- SETTLE, 8: cycles after any tap change during which pd_valid is ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins (or restarts) the lock sequence
- pd_valid  in  1  phase-detector sample is valid this cycle
- pd_late  in  1  1 = delayed edge late (decrease tap); 0 = early (increase tap)
- manual_en  in  1  override mode
- manual_tap  in  IDX_W  tap index used when manual_en=1
- en  out  TAPS  one-hot tap enable to the delay line
- tap  out  IDX_W  current tap index
- busy  out  1  high in SEARCH or TRACK
- locked  out  1  high in TRACK
- sat_err  out  1  sticky; tracking tried to step past tap 0 or TAPS-1

Behaviour:
- Reset (one clk edge with rst=1):
  - state=IDLE, tap=0, en=1<<0, busy=0, locked=0, sat_err=0.
  - filter count=0, settle count=0.
  - A reset mid-operation aborts immediately; there is no partial state.
- en is registered from tap: en = 1<<tap, one cycle after tap updates. Exactly one bit is ever set, and never zero bits, including across reset.
- A pd sample is accepted only when pd_valid=1, settle_cnt==0, and state is SEARCH or TRACK.
  - An accepted sample in cycle n updates tap at edge n+1 and en at edge n+2.
- Any tap change loads settle_cnt=SETTLE; it decrements to 0.
- Priority order: rst > manual_en > start > pd sample.
- IDLE:
  - start → SEARCH, tap=TAPS/2 (256), step=TAPS/4 (128), sat_err cleared, settle loaded.
- SEARCH:
  - Accepted sample: tap -= step if pd_late, else tap += step; then step >>= 1.
  - After the sample taken with step==1 → TRACK, locked=1, filter=0.
  - Final tap range is 1..511; no saturation is possible in SEARCH.
- TRACK:
  - Signed filter: early → +1, late → -1.
  - filter reaching +FILT_TH: tap+1 and filter=0. If tap==TAPS-1, tap holds and sat_err=1.
  - filter reaching -FILT_TH: tap-1 and filter=0. If tap==0, tap holds and sat_err=1.
  - Hitting a bound resets filter to 0 and does not load settle.
  - locked stays high in TRACK.
- start while in SEARCH or TRACK restarts SEARCH from 256.
- manual_en=1:
  - From any state → IDLE; tap=manual_tap each cycle; busy=0, locked=0.
  - start is ignored.
  - Deasserting manual_en leaves tap held in IDLE.
- Simultaneous start and pd_valid: start wins and the sample is dropped.

Decomposition:
- Package delay_pkg holds:
  - TAPS, IDX_W, FILT_TH, SETTLE defaults.
  - state enum {IDLE, SEARCH, TRACK}.
  - INIT_TAP=TAPS/2, INIT_STEP=TAPS/4.
- One natural sub-module, delay_tap_decode: registered index-to-one-hot decoder (clk, rst, tap → en).
  - Resets to bit 0 and is shared with any future multi-line controller.
- The FSM, settle counter and filter stay in delay_tap_ctrl.

Test Plan:
- Reset → tap=0, en==1<<0 with popcount 1, busy=0, locked=0.
- start, then pd_late=1 on every accepted sample → tap 128,64,32,16,8,4,2,1; locked=1 after the 8th accepted sample; en==1<<1.
- start, then pd_late=0 on every accepted sample → tap reaches 511, locked=1. pd_valid pulses inside the 8-cycle settle window are ignored: tap is unchanged and the sample count is not advanced.
- In TRACK at tap=300:
  - 8 early samples → tap=301, en[301]=1 and en[300]=0 one cycle after tap.
  - Alternating early/late for 32 samples → tap stays 301.
- In TRACK at tap=511: 8 early samples → tap=511, sat_err=1. A following start clears sat_err and tap=256.
- manual_en=1 with manual_tap=37 during SEARCH → tap=37 next edge, en==1<<37 one edge later, locked=0, busy=0. rst asserted mid-SEARCH → tap=0, en[0]=1, IDLE after one edge.
